lsu_ctrl: RTL and testbench

- Load/store unit. Sits between the core's decode/execute/writeback datapath and the data memory bus.
- Accepts one load or store request at a time over a valid/ready handshake.
- Issues a word-aligned bus transaction with byte strobes. Load data is aligned and sign- or zero-extended before it is returned.
- Lets the core move from a single-cycle ideal data memory to a multicycle bus with variable latency.

---
 rtl/lsu_ctrl_if.sv | 42 ++++
 rtl/lsu_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_ctrl_if : core request/response and data-bus signals of the LSU         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // slave: the LSU's view; master: the core and memory surrounding it
    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, req_signed,
        input  rsp_ready, mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, req_signed,
        output rsp_ready, mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_ctrl : load/store unit bridging the core to a variable-latency bus.     |
// | Optional WAIT timeout enabled by defining LSU_TIMEOUT_EN.    Rev 1.0        |
// +----------------------------------------------------------------------------+
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic   clk,
    input  wire logic   rst,
    lsu_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        w_req_err;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    assign w_req_err = (bus.req_size == 2'b11)
                     || ((bus.req_size == 2'b01) && bus.req_addr[0])
                     || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    // Bus lanes are derived from the captured request so they stay stable in REQ
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = wdata_q;
        case (size_q)
            2'b00: begin
                w_wstrb = 4'b0001 << addr_q[1:0];
                w_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                w_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = wdata_q;
            end
        endcase
        if (!we_q) begin
            w_wstrb = 4'b0000;
        end
    end

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            2'd3:    w_byte = bus.mem_rdata[31:24];
            default: w_byte = bus.mem_rdata[7:0];
        endcase
        w_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            2'b00:   w_load_data = {{24{signed_q & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{signed_q & w_half[15]}}, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    if (w_req_err) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                        state_d     = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_d = WAIT;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    rsp_rdata_d = we_q ? 32'h0 : w_load_data;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                // This cycle is the TIMEOUT_CYCLES-th WAIT cycle without data
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_req   = (state_q == REQ);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_we    = we_q;
    assign bus.mem_wstrb = w_wstrb;
    assign bus.mem_wdata = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_ctrl : directed self-checking bench for lsu_ctrl                     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_lsu_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    lsu_ctrl_if u_if ();

    lsu_ctrl #(
        .TIMEOUT_CYCLES(4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic sgn);
        u_if.req_valid  = 1'b1;
        u_if.req_we     = we;
        u_if.req_size   = size;
        u_if.req_addr   = addr;
        u_if.req_wdata  = wdata;
        u_if.req_signed = sgn;
    endtask

    // Minimum-latency transaction: accept, grant, rvalid, response
    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic sgn,
                       input logic [31:0] mrdata, input logic [31:0] exp_maddr,
                       input logic [3:0] exp_strb, input logic [31:0] exp_mwdata,
                       input logic [31:0] exp_rdata);
        drive_req(we, size, addr, wdata, sgn);
        tick();
        u_if.req_valid = 1'b0;
        chk({tag, "_mem_req"}, u_if.mem_req, 1);
        chk({tag, "_req_ready"}, u_if.req_ready, 0);
        chk({tag, "_mem_addr"}, u_if.mem_addr, exp_maddr);
        chk({tag, "_mem_we"}, u_if.mem_we, we);
        chk({tag, "_mem_wstrb"}, u_if.mem_wstrb, exp_strb);
        if (we) chk({tag, "_mem_wdata"}, u_if.mem_wdata, exp_mwdata);
        u_if.mem_gnt = 1'b1;
        tick();
        u_if.mem_gnt = 1'b0;
        chk({tag, "_wait_no_req"}, u_if.mem_req, 0);
        chk({tag, "_wait_no_rsp"}, u_if.rsp_valid, 0);
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = mrdata;
        tick();
        u_if.mem_rvalid = 1'b0;
        chk({tag, "_rsp_valid"}, u_if.rsp_valid, 1);
        chk({tag, "_rsp_rdata"}, u_if.rsp_rdata, exp_rdata);
        chk({tag, "_rsp_err"}, u_if.rsp_err, 0);
        u_if.rsp_ready = 1'b1;
        tick();
        u_if.rsp_ready = 1'b0;
        chk({tag, "_back_idle"}, u_if.req_ready, 1);
        chk({tag, "_rsp_drop"}, u_if.rsp_valid, 0);
    endtask

    task automatic err_txn(input string tag, input logic [1:0] size, input logic [31:0] addr);
        drive_req(1'b0, size, addr, 32'h0, 1'b0);
        tick();
        u_if.req_valid = 1'b0;
        chk({tag, "_no_mem_req"}, u_if.mem_req, 0);
        chk({tag, "_rsp_valid"}, u_if.rsp_valid, 1);
        chk({tag, "_rsp_err"}, u_if.rsp_err, 1);
        chk({tag, "_rsp_rdata"}, u_if.rsp_rdata, 32'h0);
        u_if.rsp_ready = 1'b1;
        tick();
        u_if.rsp_ready = 1'b0;
        chk({tag, "_idle"}, u_if.req_ready, 1);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        u_if.req_valid  = 1'b0;
        u_if.req_addr   = 32'h0;
        u_if.req_wdata  = 32'h0;
        u_if.req_we     = 1'b0;
        u_if.req_size   = 2'b00;
        u_if.req_signed = 1'b0;
        u_if.rsp_ready  = 1'b0;
        u_if.mem_gnt    = 1'b0;
        u_if.mem_rvalid = 1'b0;
        u_if.mem_rdata  = 32'h0;
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_req_ready", u_if.req_ready, 1);
        chk("rst_mem_req", u_if.mem_req, 0);
        chk("rst_rsp_valid", u_if.rsp_valid, 0);
        chk("rst_mem_addr", u_if.mem_addr, 32'h0);
        chk("rst_mem_wstrb", u_if.mem_wstrb, 4'h0);
        chk("rst_mem_wdata", u_if.mem_wdata, 32'h0);
        chk("rst_rsp_rdata", u_if.rsp_rdata, 32'h0);
        chk("rst_rsp_err", u_if.rsp_err, 0);

        // Loads: byte/half/word with sign and zero extension
        txn("lb_s",  1'b0, 2'b00, 32'h8000_0003, 32'h0, 1'b1, 32'h80FF_1234,
            32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_FF80);
        txn("lb_u",  1'b0, 2'b00, 32'h8000_0003, 32'h0, 1'b0, 32'h80FF_1234,
            32'h8000_0000, 4'h0, 32'h0, 32'h0000_0080);
        txn("lb_o1", 1'b0, 2'b00, 32'h8000_0001, 32'h0, 1'b1, 32'h80FF_1234,
            32'h8000_0000, 4'h0, 32'h0, 32'h0000_0012);
        txn("lh_s",  1'b0, 2'b01, 32'h8000_0002, 32'h0, 1'b1, 32'h80FF_1234,
            32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_80FF);
        txn("lh_u",  1'b0, 2'b01, 32'h8000_0000, 32'h0, 1'b1, 32'h80FF_1234,
            32'h8000_0000, 4'h0, 32'h0, 32'h0000_1234);
        txn("lw",    1'b0, 2'b10, 32'h0000_0004, 32'h0, 1'b1, 32'hDEAD_BEEF,
            32'h0000_0004, 4'h0, 32'h0, 32'hDEAD_BEEF);

        // Stores: lane replication, strobes, zero response data
        txn("sh",    1'b1, 2'b01, 32'h8000_0002, 32'h1234_BEEF, 1'b0, 32'hFFFF_FFFF,
            32'h8000_0000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        txn("sb",    1'b1, 2'b00, 32'h8000_0001, 32'h0000_00AB, 1'b0, 32'hFFFF_FFFF,
            32'h8000_0000, 4'b0010, 32'hABAB_ABAB, 32'h0);
        txn("sw",    1'b1, 2'b10, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF,
            32'h0000_0008, 4'b1111, 32'h1234_5678, 32'h0);

        // Leave nonzero rsp_rdata behind so the error path must clear it
        txn("lw_pre", 1'b0, 2'b10, 32'h0000_000C, 32'h0, 1'b0, 32'h5555_AAAA,
            32'h0000_000C, 4'h0, 32'h0, 32'h5555_AAAA);
        err_txn("mis_w", 2'b10, 32'h8000_0001);
        err_txn("rsvd",  2'b11, 32'h8000_0000);
        err_txn("mis_h", 2'b01, 32'h8000_0003);

        // Backpressure: late grant, early rvalid, stalled response, pending request
        drive_req(1'b1, 2'b10, 32'h0000_0010, 32'hCAFE_F00D, 1'b0);
        tick();
        drive_req(1'b0, 2'b01, 32'h0000_0022, 32'h0, 1'b0);
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            chk("bp_mem_req", u_if.mem_req, 1);
            chk("bp_mem_addr", u_if.mem_addr, 32'h0000_0010);
            chk("bp_mem_wstrb", u_if.mem_wstrb, 4'hF);
            chk("bp_mem_wdata", u_if.mem_wdata, 32'hCAFE_F00D);
            chk("bp_req_ready", u_if.req_ready, 0);
            tick();
            u_if.mem_rvalid = 1'b0;
        end
        chk("bp_early_rvalid_ignored", u_if.rsp_valid, 0);
        u_if.mem_gnt    = 1'b1;
        u_if.mem_rvalid = 1'b1;
        tick();
        u_if.mem_gnt    = 1'b0;
        u_if.mem_rvalid = 1'b0;
        chk("bp_gnt_rvalid_ignored", u_if.rsp_valid, 0);
        tick();
        chk("bp_still_wait", u_if.rsp_valid, 0);
        chk("bp_wait_no_req", u_if.mem_req, 0);
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'hA5A5_1111;
        tick();
        u_if.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_valid", u_if.rsp_valid, 1);
            chk("bp_rsp_rdata", u_if.rsp_rdata, 32'h0);
            chk("bp_rsp_err", u_if.rsp_err, 0);
            chk("bp_rsp_req_ready", u_if.req_ready, 0);
            if (i == 2) u_if.rsp_ready = 1'b1;
            tick();
        end
        u_if.rsp_ready = 1'b0;
        chk("bp_idle_ready", u_if.req_ready, 1);
        chk("bp_idle_no_req", u_if.mem_req, 0);
        tick();
        u_if.req_valid = 1'b0;
        chk("bp_next_accepted", u_if.mem_req, 1);
        chk("bp_next_addr", u_if.mem_addr, 32'h0000_0020);
        u_if.mem_gnt = 1'b1;
        tick();
        u_if.mem_gnt    = 1'b0;
        u_if.mem_rvalid = 1'b1;
        tick();
        u_if.mem_rvalid = 1'b0;
        chk("bp_next_rdata", u_if.rsp_rdata, 32'h0000_A5A5);
        u_if.rsp_ready = 1'b1;
        tick();
        u_if.rsp_ready = 1'b0;

        // Asynchronous reset while in WAIT
        drive_req(1'b0, 2'b10, 32'h0000_0040, 32'h0, 1'b0);
        tick();
        u_if.req_valid = 1'b0;
        u_if.mem_gnt   = 1'b1;
        tick();
        u_if.mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstw_req_ready", u_if.req_ready, 1);
        chk("rstw_mem_req", u_if.mem_req, 0);
        chk("rstw_rsp_valid", u_if.rsp_valid, 0);
        tick();
        rst = 1'b0;
        u_if.mem_rvalid = 1'b1;
        tick();
        u_if.mem_rvalid = 1'b0;
        chk("rstw_late_rvalid", u_if.rsp_valid, 0);
        chk("rstw_idle", u_if.req_ready, 1);
        tick();
        chk("rstw_still_idle", u_if.rsp_valid, 0);

        // WAIT with no rvalid: 4-cycle timeout when enabled, unbounded otherwise
        drive_req(1'b0, 2'b10, 32'h0000_0050, 32'h0, 1'b0);
        tick();
        u_if.req_valid = 1'b0;
        u_if.mem_gnt   = 1'b1;
        tick();
        u_if.mem_gnt = 1'b0;
        repeat (3) tick();
        chk("to_wait3", u_if.rsp_valid, 0);
        tick();
`ifdef LSU_TIMEOUT_EN
        chk("to_fire", u_if.rsp_valid, 1);
        chk("to_err", u_if.rsp_err, 1);
        chk("to_rdata", u_if.rsp_rdata, 32'h0);
`else
        repeat (20) tick();
        chk("to_none", u_if.rsp_valid, 0);
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'h0BAD_F00D;
        tick();
        u_if.mem_rvalid = 1'b0;
        chk("to_late_ok", u_if.rsp_valid, 1);
        chk("to_late_err", u_if.rsp_err, 0);
        chk("to_late_rdata", u_if.rsp_rdata, 32'h0BAD_F00D);
`endif
        u_if.rsp_ready = 1'b1;
        tick();
        u_if.rsp_ready = 1'b0;

        // rvalid on the 4th WAIT cycle gives a normal response
        drive_req(1'b0, 2'b10, 32'h0000_0060, 32'h0, 1'b0);
        tick();
        u_if.req_valid = 1'b0;
        u_if.mem_gnt   = 1'b1;
        tick();
        u_if.mem_gnt = 1'b0;
        repeat (3) tick();
        u_if.mem_rvalid = 1'b1;
        u_if.mem_rdata  = 32'h7777_0001;
        tick();
        u_if.mem_rvalid = 1'b0;
        chk("to_edge_valid", u_if.rsp_valid, 1);
        chk("to_edge_err", u_if.rsp_err, 0);
        chk("to_edge_rdata", u_if.rsp_rdata, 32'h7777_0001);
        u_if.rsp_ready = 1'b1;
        tick();
        u_if.rsp_ready = 1'b0;
        chk("end_idle", u_if.req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
